mvm_noc_sequencer: RTL and testbench

Command-driven injection controller for the MVM NoC. Each accepted command programs one MVM tile: it streams up to 64 weight rows into a register file, sends one input vector, then issues one MVM instruction. It emits these as single-beat AXI-Stream packets on the NoC slave port of `mvm_top`, replacing hand-sequenced stimulus. Weight and vector payloads come from an upstream data stream; the sequencer adds destination, operation and row-select sideband and obeys NoC backpressure.

---
 rtl/mvm_noc_sequencer.sv | 165 ++++++++++++++++
 tb/tb_mvm_noc_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_noc_sequencer.sv
// Command-driven injection controller for the MVM NoC: weight rows, one input vector, one instruction per command.
// Optional build macro MVM_SEQ_TID_TAG_EN puts a per-beat sequence number on AXIS_M_TID.
module mvm_noc_sequencer #(
    parameter int DATAW     = 512,
    parameter int DESTW     = 12,
    parameter int IDW       = 12,
    parameter int MAX_LINES = 64
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   CMD_VALID,
    output logic                   CMD_READY,
    input  logic [DESTW-1:0]       CMD_DEST,
    input  logic [8:0]             CMD_RF_ADDR,
    input  logic [6:0]             CMD_LINES,
    input  logic [31:0]            CMD_INSTR,
    input  logic                   DIN_VALID,
    output logic                   DIN_READY,
    input  logic [DATAW-1:0]       DIN_DATA,
    output logic                   AXIS_M_TVALID,
    input  logic                   AXIS_M_TREADY,
    output logic [DATAW-1:0]       AXIS_M_TDATA,
    output logic [DESTW-1:0]       AXIS_M_TDEST,
    output logic [MAX_LINES+10:0]  AXIS_M_TUSER,
    output logic [IDW-1:0]         AXIS_M_TID,
    output logic                   AXIS_M_TLAST,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [1:0]             DBG_STATE
);

    localparam int USERW = 11 + MAX_LINES;
    localparam logic [6:0] MAX_LINES_W = 7'(MAX_LINES);

    typedef enum logic [1:0] {S_IDLE, S_WEIGHTS, S_VECTOR, S_INSTR} state_t;

    state_t               state, state_nxt;
    logic [DESTW-1:0]     dest_q;
    logic [8:0]           rf_addr_q;
    logic [6:0]           lines_q;
    logic [6:0]           row_q;
    logic [31:0]          instr_q;
    logic                 instr_sent_q;

    logic [6:0]           lines_clamped;
    logic                 out_free;
    logic                 cmd_fire;
    logic                 din_fire;
    logic                 instr_load;
    logic                 instr_done;
    logic                 beat_load;
    logic [DATAW-1:0]     beat_data;
    logic [USERW-1:0]     beat_user;
    logic [MAX_LINES-1:0] weight_sel;

    // Handshakes (CMD, DIN, AXIS_M): a transfer happens on a rising edge where
    // valid and ready are both high; a producer holds valid and its payload until then.
    assign lines_clamped = (CMD_LINES > MAX_LINES_W) ? MAX_LINES_W : CMD_LINES;
    assign out_free      = !AXIS_M_TVALID || AXIS_M_TREADY;
    assign cmd_fire      = CMD_VALID && (state == S_IDLE);
    assign din_fire      = DIN_VALID && DIN_READY;
    assign instr_load    = (state == S_INSTR) && !instr_sent_q && out_free;
    assign instr_done    = (state == S_INSTR) && instr_sent_q && AXIS_M_TVALID && AXIS_M_TREADY;
    assign beat_load     = din_fire || instr_load;
    assign weight_sel    = {{(MAX_LINES-1){1'b0}}, 1'b1} << row_q;

    assign CMD_READY = (state == S_IDLE);
    assign BUSY      = (state != S_IDLE);
    assign DIN_READY = ((state == S_WEIGHTS) || (state == S_VECTOR)) && out_free;
    assign DBG_STATE = state;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (CMD_VALID) state_nxt = (lines_clamped == 7'd0) ? S_VECTOR : S_WEIGHTS;
            S_WEIGHTS: if (din_fire && (row_q == lines_q - 7'd1)) state_nxt = S_VECTOR;
            S_VECTOR:  if (din_fire) state_nxt = S_INSTR;
            S_INSTR:   if (instr_done) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Beat contents depend only on the phase the beat is loaded in.
    always_comb begin
        beat_data = DIN_DATA;
        beat_user = '0;
        case (state)
            S_WEIGHTS: beat_user = {weight_sel, 2'b11, rf_addr_q};
            S_VECTOR:  beat_user = {{MAX_LINES{1'b0}}, 2'b10, 9'd0};
            S_INSTR:   beat_data = {{(DATAW-32){1'b0}}, instr_q};
            default:   beat_user = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dest_q       <= '0;
            rf_addr_q    <= '0;
            lines_q      <= '0;
            row_q        <= '0;
            instr_q      <= '0;
            instr_sent_q <= 1'b0;
        end else begin
            if (cmd_fire) begin
                dest_q       <= CMD_DEST;
                rf_addr_q    <= CMD_RF_ADDR;
                lines_q      <= lines_clamped;
                instr_q      <= CMD_INSTR;
                row_q        <= '0;
                instr_sent_q <= 1'b0;
            end else begin
                if (din_fire && (state == S_WEIGHTS)) row_q <= row_q + 7'd1;
                if (instr_load) instr_sent_q <= 1'b1;
            end
        end
    end

    // Single output register: refills when empty or on the same edge its beat leaves.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            AXIS_M_TVALID <= 1'b0;
            AXIS_M_TDATA  <= '0;
            AXIS_M_TDEST  <= '0;
            AXIS_M_TUSER  <= '0;
            AXIS_M_TLAST  <= 1'b0;
            DONE          <= 1'b0;
        end else begin
            DONE <= instr_done;
            if (beat_load) begin
                AXIS_M_TVALID <= 1'b1;
                AXIS_M_TDATA  <= beat_data;
                AXIS_M_TDEST  <= dest_q;
                AXIS_M_TUSER  <= beat_user;
                AXIS_M_TLAST  <= 1'b1;
            end else if (AXIS_M_TREADY) begin
                AXIS_M_TVALID <= 1'b0;
            end
        end
    end

`ifdef MVM_SEQ_TID_TAG_EN
    logic [IDW-1:0] tid_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tid_q <= '0;
        end else if (AXIS_M_TVALID && AXIS_M_TREADY) begin
            tid_q <= tid_q + {{(IDW-1){1'b0}}, 1'b1};
        end
    end

    assign AXIS_M_TID = tid_q;
`else
    assign AXIS_M_TID = '0;
`endif

endmodule

// File: tb/tb_mvm_noc_sequencer.sv
// Self-checking bench for mvm_noc_sequencer: random DIN/TREADY stimulus against a queue-based packet model.
module tb_mvm_noc_sequencer;

    localparam int DATAW     = 512;
    localparam int DESTW     = 12;
    localparam int IDW       = 12;
    localparam int MAX_LINES = 64;
    localparam int USERW     = 11 + MAX_LINES;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              cmd_valid, cmd_ready;
    logic [DESTW-1:0]  cmd_dest;
    logic [8:0]        cmd_rf_addr;
    logic [6:0]        cmd_lines;
    logic [31:0]       cmd_instr;
    logic              din_valid, din_ready;
    logic [DATAW-1:0]  din_data;
    logic              tvalid, tready, tlast;
    logic [DATAW-1:0]  tdata;
    logic [DESTW-1:0]  tdest;
    logic [USERW-1:0]  tuser;
    logic [IDW-1:0]    tid;
    logic              busy, done;
    logic [1:0]        dbg_state;

    mvm_noc_sequencer #(.DATAW(DATAW), .DESTW(DESTW), .IDW(IDW), .MAX_LINES(MAX_LINES)) dut (
        .CLK(clk), .RST_N(rst_n),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_DEST(cmd_dest),
        .CMD_RF_ADDR(cmd_rf_addr), .CMD_LINES(cmd_lines), .CMD_INSTR(cmd_instr),
        .DIN_VALID(din_valid), .DIN_READY(din_ready), .DIN_DATA(din_data),
        .AXIS_M_TVALID(tvalid), .AXIS_M_TREADY(tready), .AXIS_M_TDATA(tdata),
        .AXIS_M_TDEST(tdest), .AXIS_M_TUSER(tuser), .AXIS_M_TID(tid), .AXIS_M_TLAST(tlast),
        .BUSY(busy), .DONE(done), .DBG_STATE(dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input bit ok, input string name, input logic [DATAW-1:0] act, input logic [DATAW-1:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DATAW-1:0] rand_word();
        logic [DATAW-1:0] w;
        for (int i = 0; i < DATAW/32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    // ---------------- behavioural model / scoreboard ----------------
    logic [DATAW-1:0] exp_q[$];          // DIN words accepted, awaiting their output beat
    logic [USERW-1:0] log_user[$];
    logic [DATAW-1:0] log_data[$];
    logic [IDW-1:0]   log_tid[$];
    int               log_cyc[$];

    bit               m_active;
    int               m_lines, m_k, m_din_cnt;
    logic [DESTW-1:0] m_dest;
    logic [8:0]       m_rf;
    logic [31:0]      m_instr;
    bit               done_exp;
    logic [31:0]      hs_total;
    int               done_cnt = 0;
    bit               din_taken, cmd_taken;
    bit               prev_stall;
    logic [DATAW-1:0] p_tdata;
    logic [DESTW-1:0] p_tdest;
    logic [USERW-1:0] p_tuser;
    logic [IDW-1:0]   p_tid;

    task automatic model_clear();
        exp_q.delete();
        m_active = 0; m_lines = 0; m_k = 0; m_din_cnt = 0;
        done_exp = 0; hs_total = 0; prev_stall = 0;
        din_taken = 0; cmd_taken = 0;
    endtask

    initial model_clear();

    always @(negedge clk) begin
        logic [DATAW-1:0] e_data;
        logic [USERW-1:0] e_user;
        logic [IDW-1:0]   e_tid;
        bit               done_next;
        bit               e_din_ready;
        cyc++;
        if (!rst_n) begin
            chk(!tvalid && !tlast && !din_ready && !busy && !done && cmd_ready, "reset_ctrl",
                {tvalid, tlast, din_ready, busy, done, cmd_ready}, 6'b000001);
            chk(tdata == '0 && tdest == '0 && tuser == '0 && tid == '0, "reset_data",
                tdata ^ DATAW'(tuser) ^ DATAW'(tdest) ^ DATAW'(tid), '0);
            model_clear();
        end else begin
            done_next = 0;
            chk(done == done_exp, "done", DATAW'(done), DATAW'(done_exp));
            chk(busy == m_active, "busy", DATAW'(busy), DATAW'(m_active));
            chk(cmd_ready == !m_active, "cmd_ready", DATAW'(cmd_ready), DATAW'(!m_active));
            if (prev_stall) begin
                chk(tvalid && tdata == p_tdata && tdest == p_tdest && tuser == p_tuser && tid == p_tid,
                    "stall_stable", DATAW'(tuser), DATAW'(p_tuser));
            end
            e_din_ready = m_active && (m_din_cnt < m_lines + 1) && (!tvalid || tready);
            chk(din_ready == e_din_ready, "din_ready", DATAW'(din_ready), DATAW'(e_din_ready));
            if (tvalid) chk(tlast && tdest == m_dest, "tlast_tdest", DATAW'({tlast, tdest}), DATAW'({1'b1, m_dest}));

            if (tvalid && tready) begin
                e_data = '0;
                e_user = '0;
                if (!m_active) begin
                    chk(0, "spurious_beat", DATAW'(tuser), '0);
                end else begin
                    if (m_k < m_lines) begin
                        chk(exp_q.size() > 0, "weight_src", DATAW'(exp_q.size()), 1);
                        if (exp_q.size() > 0) e_data = exp_q.pop_front();
                        e_user[8:0]     = m_rf;
                        e_user[10:9]    = 2'b11;
                        e_user[11+m_k]  = 1'b1;
                    end else if (m_k == m_lines) begin
                        chk(exp_q.size() > 0, "vector_src", DATAW'(exp_q.size()), 1);
                        if (exp_q.size() > 0) e_data = exp_q.pop_front();
                        e_user[10:9]    = 2'b10;
                    end else begin
                        e_data[31:0]    = m_instr;
                        done_next       = 1;
                    end
`ifdef MVM_SEQ_TID_TAG_EN
                    e_tid = hs_total[IDW-1:0];
`else
                    e_tid = '0;
`endif
                    chk(tdata == e_data, "beat_data", tdata, e_data);
                    chk(tuser == e_user, "beat_user", DATAW'(tuser), DATAW'(e_user));
                    chk(tid == e_tid, "beat_tid", DATAW'(tid), DATAW'(e_tid));
                    m_k++;
                end
                hs_total++;
                log_user.push_back(tuser);
                log_data.push_back(tdata);
                log_tid.push_back(tid);
                log_cyc.push_back(cyc);
            end

            din_taken = din_valid && din_ready;
            cmd_taken = cmd_valid && cmd_ready;
            if (din_taken) begin
                exp_q.push_back(din_data);
                m_din_cnt++;
            end
            if (done) done_cnt++;
            if (done_next) begin
                chk(m_din_cnt == m_lines + 1, "din_consumed", DATAW'(m_din_cnt), DATAW'(m_lines + 1));
                m_active = 0;
            end
            if (cmd_taken) begin
                m_active  = 1;
                m_dest    = cmd_dest;
                m_rf      = cmd_rf_addr;
                m_instr   = cmd_instr;
                m_lines   = (int'(cmd_lines) > MAX_LINES) ? MAX_LINES : int'(cmd_lines);
                m_k       = 0;
                m_din_cnt = 0;
            end
            done_exp   = done_next;
            prev_stall = tvalid && !tready;
            p_tdata = tdata; p_tdest = tdest; p_tuser = tuser; p_tid = tid;
        end
    end

    // ---------------- drivers ----------------
    int din_mode = 0;   // 0: idle, 1: always valid, 2: random valid
    int tr_mode  = 0;   // 0: TREADY high, 1: random TREADY

    initial begin
        din_valid = 0;
        din_data  = '0;
        tready    = 1;
        forever begin
            @(posedge clk);
            #1;
            tready = (tr_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (!din_valid || din_taken) begin
                din_data  = rand_word();
                din_valid = (din_mode == 1) || (din_mode == 2 && $urandom_range(0, 1) == 1);
            end
        end
    end

    task automatic send_cmd(input logic [DESTW-1:0] d, input logic [8:0] rf, input logic [6:0] ln,
                            input logic [31:0] ins, input bit wait_fin);
        int n;
        int d0;
        @(posedge clk);
        #1;
        cmd_valid = 1; cmd_dest = d; cmd_rf_addr = rf; cmd_lines = ln; cmd_instr = ins;
        d0 = done_cnt;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!cmd_taken && n < 200);
        chk(cmd_taken, "cmd_accept_timeout", DATAW'(n), 200);
        @(posedge clk);
        #1;
        cmd_valid = 0;
        if (wait_fin) begin
            n = 0;
            while (done_cnt == d0 && n < 4000) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk(done_cnt > d0, "done_timeout", DATAW'(n), 4000);
        end
    endtask

    task automatic log_clear();
        log_user.delete(); log_data.delete(); log_tid.delete(); log_cyc.delete();
    endtask

    task automatic wait_beats(input int cnt);
        int n = 0;
        while (log_user.size() < cnt && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(log_user.size() >= cnt, "beat_wait_timeout", DATAW'(log_user.size()), DATAW'(cnt));
    endtask

    // ---------------- test sequence ----------------
    logic [USERW-1:0] u64[$];
    int d0;

    initial begin
        cmd_valid = 0; cmd_dest = '0; cmd_rf_addr = '0; cmd_lines = '0; cmd_instr = '0;
        rst_n = 0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1;

        // Basic load: five back-to-back beats, literal TUSER/TDATA pins.
        din_mode = 1; tr_mode = 0;
        log_clear();
        d0 = done_cnt;
        send_cmd(12'h001, 9'd1, 7'd3, 32'h80C0200A, 1);
        repeat (3) @(negedge clk);
        #1;
        chk(log_user.size() == 5, "basic_count", DATAW'(log_user.size()), 5);
        chk(log_user[0] == 75'hE01, "basic_w0", DATAW'(log_user[0]), 75'hE01);
        chk(log_user[1] == 75'h1601, "basic_w1", DATAW'(log_user[1]), 75'h1601);
        chk(log_user[2] == 75'h2601, "basic_w2", DATAW'(log_user[2]), 75'h2601);
        chk(log_user[3] == 75'h400, "basic_vec", DATAW'(log_user[3]), 75'h400);
        chk(log_user[4] == '0 && log_data[4] == DATAW'(32'h80C0200A), "basic_instr", log_data[4], DATAW'(32'h80C0200A));
        chk(log_cyc[4] - log_cyc[0] == 4, "basic_consecutive", DATAW'(log_cyc[4] - log_cyc[0]), 4);
        chk(done_cnt - d0 == 1, "basic_one_done", DATAW'(done_cnt - d0), 1);
`ifdef MVM_SEQ_TID_TAG_EN
        for (int i = 0; i < 5; i++) chk(log_tid[i] == IDW'(i), "tid_seq", DATAW'(log_tid[i]), DATAW'(i));
`else
        for (int i = 0; i < 5; i++) chk(log_tid[i] == '0, "tid_zero", DATAW'(log_tid[i]), '0);
`endif

        // Full 64 rows, then 100 clamps to the same sideband sequence.
        log_clear();
        send_cmd(12'h2A5, 9'h1F0, 7'd64, 32'h12345678, 1);
        chk(log_user.size() == 66, "full_count", DATAW'(log_user.size()), 66);
        chk(log_user[63][74] == 1'b1 && log_user[63][73:11] == '0, "full_last_row", DATAW'(log_user[63]), 0);
        u64 = log_user;
        log_clear();
        send_cmd(12'h2A5, 9'h1F0, 7'd100, 32'h12345678, 1);
        chk(log_user.size() == 66, "clamp_count", DATAW'(log_user.size()), 66);
        for (int i = 0; i < 66; i++) chk(log_user[i] == u64[i], "clamp_user", DATAW'(log_user[i]), DATAW'(u64[i]));

        // Skip weights.
        log_clear();
        send_cmd(12'h007, 9'd5, 7'd0, 32'hDEADBEEF, 1);
        chk(log_user.size() == 2, "skip_count", DATAW'(log_user.size()), 2);
        chk(log_user[0] == 75'h400, "skip_vec", DATAW'(log_user[0]), 75'h400);

        // Random backpressure and DIN gaps.
        din_mode = 2; tr_mode = 1;
        for (int i = 0; i < 8; i++) begin
            send_cmd(DESTW'($urandom()), 9'($urandom()), 7'($urandom_range(0, 70)), $urandom(), 1);
        end

        // DIN starvation mid-weights.
        din_mode = 1; tr_mode = 0;
        log_clear();
        send_cmd(12'h055, 9'd9, 7'd20, 32'h0000_0F0F, 0);
        wait_beats(5);
        din_mode = 0;
        repeat (6) @(negedge clk);
        #1;
        chk(!tvalid, "starve_drain", DATAW'(tvalid), 0);
        repeat (4) @(negedge clk);
        din_mode = 1;
        d0 = 0;
        while (busy && d0 < 500) begin
            @(negedge clk);
            #1;
            d0++;
        end
        chk(log_user.size() == 22, "starve_count", DATAW'(log_user.size()), 22);

        // Reset mid-command, then restart at row 0.
        log_clear();
        send_cmd(12'h0F0, 9'd3, 7'd10, 32'hCAFE0001, 0);
        wait_beats(2);
        @(posedge clk);
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        log_clear();
        send_cmd(12'h0F1, 9'd4, 7'd3, 32'hCAFE0002, 1);
        chk(log_user[0] == 75'hE04, "post_reset_row0", DATAW'(log_user[0]), 75'hE04);
`ifdef MVM_SEQ_TID_TAG_EN
        chk(log_tid[0] == '0, "post_reset_tid", DATAW'(log_tid[0]), 0);
`endif
        // Back-to-back commands.
        send_cmd(12'h111, 9'd0, 7'd2, 32'h1, 1);
        send_cmd(12'h222, 9'd0, 7'd1, 32'h2, 1);

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout t=%0t actual=running required=finished", $time);
        $fatal(1, "global timeout");
    end

endmodule
